// File: rtl/servant_gpio_bank_if.sv
// Wishbone slave bus bundle for servant_gpio_bank: word address, write data/strobes,
// registered read data and acknowledge.
interface servant_gpio_bank_if;
    logic [2:0]  adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
    logic        cyc;
    logic [31:0] rdt;
    logic        ack;

    modport master (output adr, dat, sel, we, cyc, input rdt, ack);
    modport slave  (input adr, dat, sel, we, cyc, output rdt, ack);
endinterface

// File: rtl/servant_gpio_bank.sv
// Multi-bit GPIO bank for the servant SoC: direction, atomic set/clear, synchronised inputs,
// and (when GPIO_BANK_IRQ_EN is defined) edge interrupts with write-1-to-clear status.
module servant_gpio_bank #(
    parameter int          WIDTH     = 8,
    parameter logic [31:0] RESET_OUT = 32'h0
) (
    input  logic                 i_wb_clk,
    input  logic                 i_wb_rst,
    servant_gpio_bank_if.slave   wb,
    input  logic [WIDTH-1:0]     i_gpio,
    output logic [WIDTH-1:0]     o_gpio,
    output logic [WIDTH-1:0]     o_gpio_oe,
    output logic                 o_irq
);
    logic [WIDTH-1:0] r_dout;
    logic [WIDTH-1:0] r_dir;
    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic             r_ack;
    logic [31:0]      r_rdt;

    logic [31:0]      w_lane_mask;
    logic [31:0]      w_wdata;
    logic [WIDTH-1:0] w_wd;
    logic [WIDTH-1:0] w_bm;
    logic             w_acc;
    logic             w_wr;
    logic [31:0]      w_rd;
    logic             w_unused;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign w_lane_mask[gi*8 +: 8] = {8{wb.sel[gi]}};
        end
    endgenerate

    assign w_wdata  = wb.dat & w_lane_mask;
    assign w_wd     = w_wdata[WIDTH-1:0];
    assign w_bm     = w_lane_mask[WIDTH-1:0];
    assign w_unused = ^{w_wdata, w_lane_mask};
    // Ack can never assert on two consecutive cycles, so each access is accepted exactly once.
    assign w_acc    = wb.cyc & ~r_ack;
    assign w_wr     = w_acc & wb.we;

`ifdef GPIO_BANK_IRQ_EN
    logic [WIDTH-1:0] r_en;
    logic [WIDTH-1:0] r_stat;
    logic [WIDTH-1:0] r_pol;
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] w_event;
    logic [WIDTH-1:0] w_clr;

    assign w_event = r_en & ((r_pol & r_sync2 & ~r_prev) | (~r_pol & ~r_sync2 & r_prev));
    assign w_clr   = (w_wr && wb.adr == 3'd6) ? w_wd : '0;
    assign o_irq   = |(r_stat & r_en);

    always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
        if (i_wb_rst) begin
            r_en   <= '0;
            r_stat <= '0;
            r_pol  <= '0;
            r_prev <= '0;
        end else begin
            r_prev <= r_sync2;
            // A coincident hardware event beats the software clear.
            r_stat <= (r_stat & ~w_clr) | w_event;
            if (w_wr && wb.adr == 3'd5)
                r_en <= (r_en & ~w_bm) | w_wd;
            if (w_wr && wb.adr == 3'd7)
                r_pol <= (r_pol & ~w_bm) | w_wd;
        end
    end
`else
    assign o_irq = 1'b0;
`endif

    always_comb begin
        w_rd = '0;
        case (wb.adr)
            3'd0:    w_rd = 32'(r_dout);
            3'd1:    w_rd = 32'(r_sync2);
            3'd2:    w_rd = 32'(r_dir);
`ifdef GPIO_BANK_IRQ_EN
            3'd5:    w_rd = 32'(r_en);
            3'd6:    w_rd = 32'(r_stat);
            3'd7:    w_rd = 32'(r_pol);
`endif
            default: w_rd = '0;
        endcase
    end

    always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
        if (i_wb_rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= i_gpio;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
        if (i_wb_rst) begin
            r_ack  <= 1'b0;
            r_rdt  <= '0;
            r_dout <= RESET_OUT[WIDTH-1:0];
            r_dir  <= '0;
        end else begin
            r_ack <= w_acc;
            r_rdt <= w_acc ? w_rd : '0;
            if (w_wr) begin
                case (wb.adr)
                    3'd0:    r_dout <= (r_dout & ~w_bm) | w_wd;
                    3'd2:    r_dir  <= (r_dir & ~w_bm) | w_wd;
                    3'd3:    r_dout <= r_dout | w_wd;
                    3'd4:    r_dout <= r_dout & ~w_wd;
                    default: ;
                endcase
            end
        end
    end

    assign wb.ack    = r_ack;
    assign wb.rdt    = r_rdt;
    assign o_gpio    = r_dout;
    assign o_gpio_oe = r_dir;
endmodule
